// File: rtl/sram_arbiter.sv
// Write-buffering arbiter between a capture write stream and a readout port sharing one SRAM.
// Define SRAM_ARB_STARVE_GUARD_EN to let a waiting read pre-empt a long write stream.
module sram_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              sram_wren,
    output logic [DATA_W-1:0] sram_d,
    output logic [ADDR_W-1:0] sram_address,
    input  logic [DATA_W-1:0] sram_q,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic              busy
);

    localparam int FIFO_W = ADDR_W + DATA_W;

    if (RD_LAT < 1 || RD_LAT > 7 || STARVE_MAX < 1) begin : g_bad_param
        $error("sram_arbiter: RD_LAT must be 1..7 and STARVE_MAX >= 1");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

    state_t state_reg, state_next;

    logic [FIFO_W-1:0] fifo_mem [4];
    logic [1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [2:0]        count_reg, count_next;
    logic              fifo_empty, fifo_full;
    logic              push, store, pop;
    logic              write_avail;
    logic [FIFO_W-1:0] head_entry;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    logic              issue_write, grant_read, read_last, starve_hit;
    logic [2:0]        rd_cnt_reg, rd_cnt_next;

    logic              wren_next, ack_next, valid_next, overflow_next;
    logic [ADDR_W-1:0] address_next;
    logic [DATA_W-1:0] d_next, rd_data_next;

    assign fifo_empty = (count_reg == 3'd0);
    assign fifo_full  = (count_reg == 3'd4);
    assign wr_ready   = !fifo_full;
    assign push       = wr_req && wr_ready;
    assign busy       = (state_reg != IDLE) || !fifo_empty;

    // An empty FIFO passes the incoming write straight through, giving one-cycle write latency.
    assign write_avail = !fifo_empty || push;
    assign head_entry  = fifo_empty ? {wr_addr, wr_data} : fifo_mem[rd_ptr_reg];
    assign head_addr   = head_entry[FIFO_W-1:DATA_W];
    assign head_data   = head_entry[DATA_W-1:0];
    assign store       = push && !(fifo_empty && issue_write);
    assign pop         = issue_write && !fifo_empty;
    assign count_next  = count_reg + {2'b00, store} - {2'b00, pop};

    assign read_last = (state_reg == READ) && (rd_cnt_reg == 3'(RD_LAT - 1));

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    logic [SC_W-1:0] starve_cnt_reg, starve_cnt_next;

    assign starve_hit = (starve_cnt_reg >= SC_W'(STARVE_MAX));

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!rd_req || grant_read) begin
            starve_cnt_next = '0;
        end else if (issue_write && !starve_hit) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (store) begin
            fifo_mem[wr_ptr_reg] <= {wr_addr, wr_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
        end else begin
            if (store) wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (pop)   rd_ptr_reg <= rd_ptr_reg + 2'd1;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Writes win over reads unless the starvation guard has tripped; a granted read runs to completion.
    always_comb begin
        state_next  = state_reg;
        issue_write = 1'b0;
        grant_read  = 1'b0;
        case (state_reg)
            IDLE, WRITE: begin
                if (rd_req && starve_hit) begin
                    grant_read = 1'b1;
                    state_next = READ;
                end else if (write_avail) begin
                    issue_write = 1'b1;
                    state_next  = WRITE;
                end else if (rd_req) begin
                    grant_read = 1'b1;
                    state_next = READ;
                end else begin
                    state_next = IDLE;
                end
            end
            READ: begin
                if (read_last) begin
                    if (rd_req && fifo_empty && !push) begin
                        grant_read = 1'b1;
                        state_next = READ;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wren_next     = issue_write;
        ack_next      = grant_read;
        valid_next    = read_last;
        address_next  = sram_address;
        d_next        = sram_d;
        rd_data_next  = rd_data;
        rd_cnt_next   = rd_cnt_reg;
        overflow_next = overflow;
        if (issue_write) begin
            address_next = head_addr;
            d_next       = head_data;
        end else if (grant_read) begin
            address_next = rd_addr;
        end
        if (read_last) begin
            rd_data_next = sram_q;
        end
        if (grant_read) begin
            rd_cnt_next = 3'd0;
        end else if (state_reg == READ) begin
            rd_cnt_next = rd_cnt_reg + 3'd1;
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (wr_req && fifo_full) begin
            overflow_next = 1'b1;
        end else if (ovf_clr) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_wren    <= 1'b0;
            sram_address <= '0;
            sram_d       <= '0;
            rd_ack       <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            rd_cnt_reg   <= 3'd0;
            overflow     <= 1'b0;
        end else begin
            sram_wren    <= wren_next;
            sram_address <= address_next;
            sram_d       <= d_next;
            rd_ack       <= ack_next;
            rd_valid     <= valid_next;
            rd_data      <= rd_data_next;
            rd_cnt_reg   <= rd_cnt_next;
            overflow     <= overflow_next;
        end
    end

endmodule
